pong_game_ctrl: RTL
===================

# pong_game_ctrl

Top-level game sequencer for the Pong design. It owns the game state machine: new game, ball in play, ball relaunch and game over. It drives the score counter's `d_inc`/`d_clr` controls, tracks the remaining balls, and freezes the graphics between rallies. It sits between the ball/paddle graphics logic, which reports `hit`/`miss`, and the score counter plus text overlay.

## Interface
- `BALLS`, default 3: balls per game; range 1..3.
- `HOLD_TICKS`, default 120: refresh ticks of enforced pause after a miss or game over; 2 s at 60 Hz; range ≥1.
- `clk` input 1: system clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high; clears all state immediately.
- `btn` input 2: player buttons; nonzero means "start/launch". Level-sampled.
- `refr_tick` input 1: one-cycle pulse per video frame.
- `hit` input 1: one-cycle pulse when the ball strikes the paddle.
- `miss` input 1: one-cycle pulse when the ball passes the paddle.
- `d_inc` output 1: score increment pulse to the score counter.
- `d_clr` output 1: score clear pulse to the score counter.
- `graph_still` output 1: 1 freezes ball motion.
- `gameover` output 1: 1 while in OVER; drives the "GAME OVER" text.
- `balls_left` output 2: balls remaining, including the one in play.
- `state_o` output 2: 0 NEWGAME, 1 PLAY, 2 NEWBALL, 3 OVER.

## Operation
- **Storage.** All outputs are registered. State is held in `state`, `balls` (2 bits), `timer` (width = clog2(HOLD_TICKS+1)), and the `d_inc`/`d_clr` flops.
- **Reset values.** state = NEWGAME, `balls` = BALLS, `timer` = 0, `d_inc` = 0, `d_clr` = 0, `graph_still` = 1, `gameover` = 0.
- **Timer.**
  - Loaded with HOLD_TICKS on entry to NEWBALL or OVER.
  - Otherwise decrements by 1 on each `refr_tick` while nonzero.
  - "Expired" means `timer` == 0.
- **NEWGAME.** `graph_still` = 1; `balls` held at BALLS.
  - `btn` != 0 → PLAY, and `d_clr` = 1 for exactly one cycle.
- **PLAY.** `graph_still` = 0.
  - `miss` with `balls` == 1 → OVER; `balls` = 0; timer loaded.
  - `miss` with `balls` > 1 → NEWBALL; `balls` decrements by 1; timer loaded.
  - `hit` with no `miss` → `d_inc` = 1 for one cycle; stay in PLAY.
  - `hit` and `miss` in the same cycle: the miss is taken and no `d_inc` is issued.
- **NEWBALL.** `graph_still` = 1.
  - `btn` is ignored until the timer expires.
  - Timer expired and `btn` != 0 → PLAY. Score is not touched.
- **OVER.** `graph_still` = 1, `gameover` = 1. `btn` is ignored.
  - Timer expired → NEWGAME; `balls` reloads to BALLS.
  - The score is not cleared here, so the final score stays displayed until the next start.
- **Ignored inputs.** `hit`/`miss` outside PLAY are ignored. `d_inc` and `d_clr` are never high in the same cycle.
- **Reset mid-operation.** Reset at any point returns to reset values on the same cycle (async). Any pulse in flight is dropped.

## Timing
- **Output latency.** `d_inc` rises on the clock edge that samples `hit`, so it is high in the cycle after the `hit` pulse. `d_clr` behaves the same relative to the `btn` sample in NEWGAME. Both return to 0 on the following edge.
- **State transitions.** A transition takes effect on the sampling edge. `graph_still`, `gameover`, `balls_left` and `state_o` reflect the new state in the next cycle.
- **Pause length.** The minimum PLAY-to-PLAY relaunch is exactly HOLD_TICKS `refr_tick` pulses after the miss edge, plus the cycle in which `btn` is sampled.
- **Decrement timing.** A `refr_tick` coincident with the timer-load edge does not decrement; the load wins.
- **Back-to-back hits.** Hits on consecutive cycles give consecutive `d_inc` pulses, one per `hit` cycle, with no loss.

## Test plan
Use BALLS=3 and HOLD_TICKS=4 throughout.
- Reset, then `btn`=01 for 1 cycle → `d_clr`=1 for one cycle the next cycle; `state_o`=1; `graph_still`=0; `balls_left`=3.
- In PLAY, pulse `hit` 5 times, including 2 back-to-back → exactly 5 `d_inc` pulses, each one cycle after its `hit`.
- `miss` in PLAY → `state_o`=2, `balls_left`=2. Hold `btn`=10 before 4 `refr_tick`s → stays in NEWBALL. After the 4th tick with `btn` held → PLAY; no `d_clr`.
- Three misses → `balls_left`=0, `gameover`=1. After 4 ticks → `state_o`=0, `balls_left`=3, `gameover`=0. `btn` during OVER is ignored.
- `hit` and `miss` in the same cycle in PLAY → no `d_inc`; `balls_left` decrements; NEWBALL entered.
- Assert `reset` mid-NEWBALL with the timer at 2, and in the cycle a `d_inc` pulse is high → immediately `state_o`=0, `balls_left`=3, `d_inc`=0, timer=0.

Source files
------------

// File: rtl/pong_game_ctrl_if.sv
// Control bundle between the Pong game sequencer and the graphics/score logic.
// The master side is the sequencer; the slave side is the graphics, score and text logic.
interface pong_game_ctrl_if;
   logic [1:0] btn;
   logic       refr_tick;
   logic       hit;
   logic       miss;
   logic       d_inc;
   logic       d_clr;
   logic       graph_still;
   logic       gameover;
   logic [1:0] balls_left;
   logic [1:0] state_o;

   modport master (
      input  btn, refr_tick, hit, miss,
      output d_inc, d_clr, graph_still, gameover, balls_left, state_o
   );

   modport slave (
      output btn, refr_tick, hit, miss,
      input  d_inc, d_clr, graph_still, gameover, balls_left, state_o
   );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: new game, ball in play, relaunch pause and game over.
// It drives the score counter controls, tracks the remaining balls and freezes the graphics.
module pong_game_ctrl #(
   parameter int unsigned BALLS      = 3,
   parameter int unsigned HOLD_TICKS = 120
) (
   input logic              clk,
   input logic              reset,
   pong_game_ctrl_if.master bus
);
   localparam int unsigned TW         = $clog2(HOLD_TICKS + 1);
   localparam logic [1:0]  BALLS_INIT = 2'(BALLS);
   localparam logic [TW-1:0] HOLD_INIT = TW'(HOLD_TICKS);

   typedef enum logic [1:0] {
      NEWGAME = 2'd0,
      PLAY    = 2'd1,
      NEWBALL = 2'd2,
      OVER    = 2'd3
   } state_t;

   state_t        state, state_next;
   logic [1:0]    balls, balls_next;
   logic [TW-1:0] timer, timer_next;
   logic          d_inc_q, d_inc_next;
   logic          d_clr_q, d_clr_next;
   logic          graph_still_q, graph_still_next;
   logic          gameover_q, gameover_next;
   logic          expired;
   logic          start;

   assign expired = (timer == '0);
   assign start   = (bus.btn != 2'b00);

   // State and datapath registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= NEWGAME;
         balls         <= BALLS_INIT;
         timer         <= '0;
         d_inc_q       <= 1'b0;
         d_clr_q       <= 1'b0;
         graph_still_q <= 1'b1;
         gameover_q    <= 1'b0;
      end else begin
         state         <= state_next;
         balls         <= balls_next;
         timer         <= timer_next;
         d_inc_q       <= d_inc_next;
         d_clr_q       <= d_clr_next;
         graph_still_q <= graph_still_next;
         gameover_q    <= gameover_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         NEWGAME: if (start) state_next = PLAY;
         PLAY:    if (bus.miss) state_next = (balls == 2'd1) ? OVER : NEWBALL;
         NEWBALL: if (expired && start) state_next = PLAY;
         OVER:    if (expired) state_next = NEWGAME;
         default: state_next = NEWGAME;
      endcase
   end

   // Output and datapath next values; a miss-edge timer load beats a coincident tick
   always_comb begin
      balls_next       = balls;
      timer_next       = timer;
      d_inc_next       = 1'b0;
      d_clr_next       = 1'b0;
      graph_still_next = (state_next != PLAY);
      gameover_next    = (state_next == OVER);

      if (state == PLAY && bus.miss)
         timer_next = HOLD_INIT;
      else if (bus.refr_tick && !expired)
         timer_next = timer - TW'(1);

      case (state)
         NEWGAME: begin
            balls_next = BALLS_INIT;
            d_clr_next = start;
         end
         PLAY: begin
            if (bus.miss)
               balls_next = balls - 2'd1;
            else
               d_inc_next = bus.hit;
         end
         OVER:    if (expired) balls_next = BALLS_INIT;
         default: balls_next = balls;
      endcase
   end

   assign bus.d_inc       = d_inc_q;
   assign bus.d_clr       = d_clr_q;
   assign bus.graph_still = graph_still_q;
   assign bus.gameover    = gameover_q;
   assign bus.balls_left  = balls;
   assign bus.state_o     = state;
endmodule
